// File: rtl/ring_pkg.sv
// Shared definitions for the ring scan phase monitor: one-cold phase codes,
// the lock state encoding and a helper that classifies a sampled code.
package ring_pkg;

    localparam logic [3:0] PH0_CODE  = 4'b1110;
    localparam logic [3:0] PH1_CODE  = 4'b1101;
    localparam logic [3:0] PH2_CODE  = 4'b1011;
    localparam logic [3:0] PH3_CODE  = 4'b0111;
    localparam logic [3:0] IDLE_CODE = 4'b0000;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } ring_state_t;

    // legal: one of the four one-cold codes (idx valid)
    // illegal: neither one-cold nor the idle 0000 pattern
    typedef struct packed {
        logic       legal;
        logic       illegal;
        logic [1:0] idx;
    } code_class_t;

    function automatic code_class_t classify(input logic [3:0] code);
        code_class_t c;
        c.legal   = 1'b1;
        c.illegal = 1'b0;
        c.idx     = 2'd0;
        case (code)
            PH0_CODE:  c.idx = 2'd0;
            PH1_CODE:  c.idx = 2'd1;
            PH2_CODE:  c.idx = 2'd2;
            PH3_CODE:  c.idx = 2'd3;
            IDLE_CODE: c.legal = 1'b0;
            default: begin
                c.legal   = 1'b0;
                c.illegal = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ring_phase_monitor_if.sv
// Bundle of the monitor's sample inputs and decoded/status outputs.
//
// Handshake: en is a one-directional sample strobe with no backpressure.
// p_in and clr_err are evaluated on every rising clk edge where en=1
// (clr_err on every edge regardless of en); all outputs are registered and
// reflect that sample one clock later. The monitor can never stall the source.
interface ring_phase_monitor_if #(
    parameter int ERR_W = 8
);
    import ring_pkg::*;

    logic             en;
    logic [3:0]       p_in;
    logic             clr_err;
    logic [1:0]       phase;
    logic             phase_vld;
    logic             locked;
    logic             seq_err;
    logic             ill_err;
    logic [ERR_W-1:0] err_cnt;
    ring_state_t      state;

    modport master (
        output en, p_in, clr_err,
        input  phase, phase_vld, locked, seq_err, ill_err, err_cnt, state
    );

    modport slave (
        input  en, p_in, clr_err,
        output phase, phase_vld, locked, seq_err, ill_err, err_cnt, state
    );

endinterface

// File: rtl/ring_phase_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // count events, stick at all-ones, clear wins over a coincident event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// Receive-side monitor for the 4-phase active-low ring scan generator.
// Decodes the one-cold phase bus, checks in-order advance, locks onto the
// sequence and reports sequence/illegal-code errors with a saturating count.
//
// Build option RING_MON_STICKY_EN: when defined, seq_err and ill_err are
// sticky levels cleared only by clr_err or reset; otherwise they are
// single-cycle pulses. err_cnt behaves the same in both builds.
module ring_phase_monitor
    import ring_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int ERR_W      = 8,
    parameter int ALLOW_HOLD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    ring_phase_monitor_if.slave   bus
);

    localparam logic [4:0] LOCK_TGT = 5'(LOCK_CNT);
    localparam logic       HOLD_OK  = (ALLOW_HOLD != 0);

    ring_state_t state_q;
    logic [3:0]  run_q;
    // phase_q is both the decoded output and the previous-phase reference
    logic [1:0]  phase_q;
    logic        phase_vld_q;
    logic        seq_q;
    logic        ill_q;

    code_class_t cls;
    logic        is_next;
    logic        is_hold;
    logic        seq_ev;
    logic        ill_ev;
    logic [4:0]  run_inc;

    // classify the sample and derive this cycle's error events
    always_comb begin
        cls     = classify(bus.p_in);
        is_next = (cls.idx == (phase_q + 2'd1));
        is_hold = HOLD_OK && (cls.idx == phase_q);
        run_inc = {1'b0, run_q} + 5'd1;
        seq_ev  = bus.en && cls.legal && (state_q != UNLOCKED) && !is_next && !is_hold;
        ill_ev  = bus.en && cls.illegal && (state_q != UNLOCKED);
    end

    // lock FSM with registered phase/status/error outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= UNLOCKED;
            run_q       <= 4'd0;
            phase_q     <= 2'd0;
            phase_vld_q <= 1'b0;
            seq_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
`ifdef RING_MON_STICKY_EN
            if (bus.clr_err) begin
                seq_q <= 1'b0;
                ill_q <= 1'b0;
            end else begin
                if (seq_ev) seq_q <= 1'b1;
                if (ill_ev) ill_q <= 1'b1;
            end
`else
            seq_q <= seq_ev && !bus.clr_err;
            ill_q <= ill_ev && !bus.clr_err;
`endif
            if (bus.en) begin
                if (cls.legal) begin
                    phase_q     <= cls.idx;
                    phase_vld_q <= 1'b1;
                end else begin
                    phase_vld_q <= 1'b0;
                end
                case (state_q)
                    UNLOCKED: begin
                        if (cls.legal) begin
                            state_q <= LOCKING;
                            run_q   <= 4'd1;
                        end
                    end
                    LOCKING: begin
                        if (cls.legal) begin
                            if (is_next) begin
                                run_q <= run_inc[3:0];
                                if (run_inc >= LOCK_TGT) state_q <= LOCKED;
                            end else if (!is_hold) begin
                                // out of order: re-seed the run from this code
                                run_q <= 4'd1;
                            end
                        end else begin
                            state_q <= UNLOCKED;
                            run_q   <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (cls.legal) begin
                            if (!is_next && !is_hold) begin
                                state_q <= LOCKING;
                                run_q   <= 4'd1;
                            end
                        end else begin
                            // illegal code or generator reset (idle) drops lock
                            state_q <= UNLOCKED;
                            run_q   <= 4'd0;
                        end
                    end
                    default: begin
                        state_q <= UNLOCKED;
                        run_q   <= 4'd0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (seq_ev | ill_ev),
        .clr   (bus.clr_err),
        .count (bus.err_cnt)
    );

    assign bus.phase     = phase_q;
    assign bus.phase_vld = phase_vld_q;
    assign bus.locked    = (state_q == LOCKED);
    assign bus.seq_err   = seq_q;
    assign bus.ill_err   = ill_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Bench for ring_phase_monitor: three parameterisations driven by one shared
// stimulus stream, each compared every cycle against a run-length model.
module tb_ring_phase_monitor;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic       en_d  = 1'b0;
    logic [3:0] p_d   = 4'b0000;
    logic       clr_d = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    // dut0: LOCK_CNT=4 ERR_W=8 no hold; dut1: ERR_W=2; dut2: hold, LOCK_CNT=3
    int lock_p[3] = '{4, 4, 3};
    int errw_p[3] = '{8, 2, 8};
    int hold_p[3] = '{0, 0, 1};

    ring_phase_monitor_if #(.ERR_W(8)) bus0 ();
    ring_phase_monitor_if #(.ERR_W(2)) bus1 ();
    ring_phase_monitor_if #(.ERR_W(8)) bus2 ();

    assign bus0.en = en_d;  assign bus0.p_in = p_d;  assign bus0.clr_err = clr_d;
    assign bus1.en = en_d;  assign bus1.p_in = p_d;  assign bus1.clr_err = clr_d;
    assign bus2.en = en_d;  assign bus2.p_in = p_d;  assign bus2.clr_err = clr_d;

    ring_phase_monitor #(.LOCK_CNT(4), .ERR_W(8), .ALLOW_HOLD(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    ring_phase_monitor #(.LOCK_CNT(4), .ERR_W(2), .ALLOW_HOLD(0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    ring_phase_monitor #(.LOCK_CNT(3), .ERR_W(8), .ALLOW_HOLD(1)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2));

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: run = length of the current in-order run (0 = no lock)
    logic [3:0] codes[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int m_run[3];
    int m_ph[3];
    bit m_vld[3];
    bit m_seq[3];
    bit m_ill[3];
    int m_cnt[3];

    function automatic int code_idx(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (codes[i] == p) return i;
        return -1;
    endfunction

    function automatic bit m_locked(input int k);
        int need = (lock_p[k] < 2) ? 2 : lock_p[k];
        return m_run[k] >= need;
    endfunction

    function automatic logic [1:0] m_state(input int k);
        if (m_run[k] == 0) return 2'd0;
        return m_locked(k) ? 2'd2 : 2'd1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_run[k] = 0; m_ph[k] = 0; m_vld[k] = 0;
            m_seq[k] = 0; m_ill[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit e, input logic [3:0] p, input bit c);
        bit ev_seq = 0;
        bit ev_ill = 0;
        int idx = code_idx(p);
        if (e) begin
            if (idx >= 0) begin
                if (m_run[k] == 0) m_run[k] = 1;
                else if (idx == (m_ph[k] + 1) % 4) m_run[k] = (m_run[k] < 1000) ? m_run[k] + 1 : 1000;
                else if (hold_p[k] != 0 && idx == m_ph[k]) m_run[k] = m_run[k];
                else begin
                    ev_seq = 1;
                    m_run[k] = 1;
                end
                m_ph[k] = idx;
                m_vld[k] = 1;
            end else begin
                if (m_run[k] > 0 && p != 4'b0000) ev_ill = 1;
                m_run[k] = 0;
                m_vld[k] = 0;
            end
        end
`ifdef RING_MON_STICKY_EN
        if (c) begin
            m_seq[k] = 0; m_ill[k] = 0;
        end else begin
            m_seq[k] = m_seq[k] | ev_seq;
            m_ill[k] = m_ill[k] | ev_ill;
        end
`else
        m_seq[k] = ev_seq && !c;
        m_ill[k] = ev_ill && !c;
`endif
        if (c) m_cnt[k] = 0;
        else if (ev_seq || ev_ill) m_cnt[k] = (m_cnt[k] < (1 << errw_p[k]) - 1) ? m_cnt[k] + 1 : m_cnt[k];
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input int k, input logic [1:0] ph, input logic vld, input logic lk,
                             input logic se, input logic ie, input logic [31:0] cnt,
                             input logic [1:0] st);
        check($sformatf("d%0d_phase", k), 32'(ph), 32'(m_ph[k]));
        check($sformatf("d%0d_phase_vld", k), 32'(vld), 32'(m_vld[k]));
        check($sformatf("d%0d_locked", k), 32'(lk), 32'(m_locked(k)));
        check($sformatf("d%0d_seq_err", k), 32'(se), 32'(m_seq[k]));
        check($sformatf("d%0d_ill_err", k), 32'(ie), 32'(m_ill[k]));
        check($sformatf("d%0d_err_cnt", k), cnt, 32'(m_cnt[k]));
        check($sformatf("d%0d_state", k), 32'(st), 32'(m_state(k)));
    endtask

    task automatic compare_all();
        check_dut(0, bus0.phase, bus0.phase_vld, bus0.locked, bus0.seq_err, bus0.ill_err,
                  32'(bus0.err_cnt), bus0.state);
        check_dut(1, bus1.phase, bus1.phase_vld, bus1.locked, bus1.seq_err, bus1.ill_err,
                  32'(bus1.err_cnt), bus1.state);
        check_dut(2, bus2.phase, bus2.phase_vld, bus2.locked, bus2.seq_err, bus2.ill_err,
                  32'(bus2.err_cnt), bus2.state);
    endtask

    // driver tasks
    task automatic apply(input bit e, input logic [3:0] p, input bit c);
        @(negedge clk);
        en_d = e; p_d = p; clr_d = c;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, e, p, c);
        #1;
        compare_all();
    endtask

    task automatic sample(input int idx);
        apply(1'b1, codes[idx % 4], 1'b0);
    endtask

    function automatic logic [3:0] pick_illegal();
        logic [3:0] p;
        do p = 4'($urandom_range(1, 15)); while (code_idx(p) >= 0);
        return p;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        en_d = 1'b0; clr_d = 1'b0;
    endtask

    initial begin
        int gidx;
        do_reset();

        // free-running generator: lock on the 4th in-order sample
        for (int i = 0; i < 3; i++) sample(i);
        check("pre_lock", 32'(bus0.locked), 32'd0);
        sample(3);
        check("lock_4th", 32'(bus0.locked), 32'd1);
        for (int i = 0; i < 4; i++) sample(i);
        check("no_err_freerun", 32'(bus0.err_cnt), 32'd0);

        // skip a phase while locked: one seq_err, relock after 3 more
        sample(0);
        sample(2);
        check("skip_seq_err", 32'(bus0.seq_err), 32'd1);
        check("skip_unlock", 32'(bus0.locked), 32'd0);
        check("skip_cnt", 32'(bus0.err_cnt), 32'd1);
        sample(3); sample(0);
        check("relock_early", 32'(bus0.locked), 32'd0);
        sample(1);
        check("relock", 32'(bus0.locked), 32'd1);

        // illegal code while locked
        apply(1'b1, 4'b1100, 1'b0);
        check("ill_pulse", 32'(bus0.ill_err), 32'd1);
        check("ill_vld", 32'(bus0.phase_vld), 32'd0);
        check("ill_phase_hold", 32'(bus0.phase), 32'd1);
        check("ill_cnt", 32'(bus0.err_cnt), 32'd2);

        // generator reset (idle) while locked, then relock
        for (int i = 0; i < 4; i++) sample(i);
        apply(1'b1, 4'b0000, 1'b0);
        check("idle_unlock", 32'(bus0.locked), 32'd0);
        check("idle_no_err", 32'(bus0.err_cnt), 32'd2);
        for (int i = 0; i < 4; i++) sample(i);
        check("idle_relock", 32'(bus0.locked), 32'd1);

        // en low: everything holds
        for (int i = 0; i < 3; i++) apply(1'b0, 4'($urandom_range(0, 15)), 1'b0);
        check("en_hold_lock", 32'(bus0.locked), 32'd1);

        // saturation on the 2-bit counter, then clear against a 6th error
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, pick_illegal(), 1'b0);
            sample(0);
        end
        check("sat_at_3", 32'(bus1.err_cnt), 32'd3);
        apply(1'b1, pick_illegal(), 1'b1);
        check("clr_wins", 32'(bus1.err_cnt), 32'd0);
        check("clr_no_pulse", 32'(bus1.ill_err), 32'd0);

        // held code: legal only on the hold-enabled instance
        sample(0);
        for (int i = 0; i < 3; i++) sample(1);
        check("hold_no_seq", 32'(bus2.seq_err), 32'd0);
        check("hold_not_locked", 32'(bus2.locked), 32'd0);
        sample(2);
        check("hold_lock", 32'(bus2.locked), 32'd1);
        sample(3);
        apply(1'b1, codes[0], 1'b1);

        // randomized generator traffic with faults, clears and a mid-run reset
        gidx = 1;
        for (int n = 0; n < 600; n++) begin
            int r = $urandom_range(0, 99);
            bit e = ($urandom_range(0, 4) != 0);
            bit c = ($urandom_range(0, 29) == 0);
            logic [3:0] p;
            if (n == 300) begin
                do_reset();
                gidx = 0;
            end
            if (r < 80) begin
                p = codes[gidx];
                if (e) gidx = (gidx + 1) % 4;
            end else if (r < 86) p = codes[(gidx + 3) % 4];
            else if (r < 91) p = codes[(gidx + 1 + $urandom_range(0, 1)) % 4];
            else if (r < 96) p = pick_illegal();
            else p = 4'b0000;
            apply(e, p, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
